// File: rtl/fp_utils_pkg.sv
// Shared helpers for the floating point datapath: word-width arithmetic, depth limits
// and lane-packing conventions.
package fp_utils_pkg;

    // Deepest pipeline the delay line supports.
    localparam int unsigned MAX_LATENCY = 64;

    // Lane-packed vectors place lane 0 in the LSBs: lane n occupies [n*W +: W].
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    // Occupancy counter must hold 0..latency and is never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/floating_point_delay_stage.sv
// One enable-gated register stage carrying a data vector and its valid bit.
module floating_point_delay_stage
    import fp_utils_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          RESET_DATA = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Flush kills the valid bit but lets data keep shifting with the enable.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (enable_i) begin
            valid_d = valid_i;
        end
        if (enable_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    if (RESET_DATA) begin : g_data_rst
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
    end else begin : g_data_no_rst
        always_ff @(posedge clk_i) begin
            data_q <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/floating_point_delay_line.sv
// Latency-matching delay line for lane-packed floating point words, with stall, flush
// and an in-flight beat counter. LATENCY=0 degenerates to a combinational pass-through.
module floating_point_delay_line
    import fp_utils_pkg::*;
#(
    parameter int unsigned EXP_WIDTH    = 8,
    parameter int unsigned FRAC_WIDTH   = 23,
    parameter int unsigned NUM_LANES    = 1,
    parameter int unsigned LATENCY      = 2,
    parameter bit          RESET_DATA   = 1'b0,
    localparam int unsigned FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int unsigned CNT_WIDTH    = cnt_width(LATENCY)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_LANES*FP_WIDTH_REG-1:0] fp_i,
    input  logic                              valid_i,
    input  logic                              enable_i,
    input  logic                              flush_i,
    output logic [NUM_LANES*FP_WIDTH_REG-1:0] fp_o,
    output logic                              valid_o,
    output logic [CNT_WIDTH-1:0]              in_flight_o
);

    localparam int unsigned VecWidth = NUM_LANES * FP_WIDTH_REG;

    if (LATENCY == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_i, enable_i};

        assign fp_o        = fp_i;
        assign valid_o     = valid_i & ~flush_i;
        assign in_flight_o = '0;
    end else begin : g_pipe
        logic [LATENCY:0]  valid_chain;
        logic [VecWidth-1:0] data_chain [LATENCY+1];
        logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

        assign valid_chain[0] = valid_i;
        assign data_chain[0]  = fp_i;

        for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
            floating_point_delay_stage #(
                .WIDTH      (VecWidth),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .enable_i (enable_i),
                .flush_i  (flush_i),
                .valid_i  (valid_chain[k-1]),
                .data_i   (data_chain[k-1]),
                .valid_o  (valid_chain[k]),
                .data_o   (data_chain[k])
            );
        end

        // Entry and exit only count on enabled edges; both together leave the count alone.
        always_comb begin
            cnt_d = cnt_q;
            if (flush_i) begin
                cnt_d = '0;
            end else if (enable_i) begin
                case ({valid_i, valid_chain[LATENCY]})
                    2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
                    2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign fp_o        = data_chain[LATENCY];
        assign valid_o     = valid_chain[LATENCY];
        assign in_flight_o = cnt_q;
    end

endmodule

// File: tb/tb_floating_point_delay_line.sv
// Directed and randomized checks of the delay line at LATENCY 3, 0 and 5.
module tb_floating_point_delay_line;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // LATENCY=3, two lanes, data reset enabled
    logic        a_rst, a_valid, a_en, a_flush;
    logic [63:0] a_fp, a_fp_o;
    logic        a_valid_o;
    logic [1:0]  a_inf;

    // LATENCY=0 pass-through
    logic        z_rst, z_valid, z_en, z_flush;
    logic [31:0] z_fp, z_fp_o;
    logic        z_valid_o;
    logic [0:0]  z_inf;

    // LATENCY=5 random stress, no data reset
    logic        r_rst, r_valid, r_en, r_flush;
    logic [31:0] r_fp, r_fp_o;
    logic        r_valid_o;
    logic [2:0]  r_inf;

    floating_point_delay_line #(
        .NUM_LANES  (2),
        .LATENCY    (3),
        .RESET_DATA (1'b1)
    ) u_l3 (
        .clk_i       (clk),
        .rst_i       (a_rst),
        .fp_i        (a_fp),
        .valid_i     (a_valid),
        .enable_i    (a_en),
        .flush_i     (a_flush),
        .fp_o        (a_fp_o),
        .valid_o     (a_valid_o),
        .in_flight_o (a_inf)
    );

    floating_point_delay_line #(
        .NUM_LANES (1),
        .LATENCY   (0)
    ) u_l0 (
        .clk_i       (clk),
        .rst_i       (z_rst),
        .fp_i        (z_fp),
        .valid_i     (z_valid),
        .enable_i    (z_en),
        .flush_i     (z_flush),
        .fp_o        (z_fp_o),
        .valid_o     (z_valid_o),
        .in_flight_o (z_inf)
    );

    floating_point_delay_line #(
        .NUM_LANES (1),
        .LATENCY   (5)
    ) u_l5 (
        .clk_i       (clk),
        .rst_i       (r_rst),
        .fp_i        (r_fp),
        .valid_i     (r_valid),
        .enable_i    (r_en),
        .flush_i     (r_flush),
        .fp_o        (r_fp_o),
        .valid_o     (r_valid_o),
        .in_flight_o (r_inf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drive(input logic rst, input logic en, input logic valid,
                           input logic flush, input logic [63:0] fp);
        a_rst   = rst;
        a_en    = en;
        a_valid = valid;
        a_flush = flush;
        a_fp    = fp;
    endtask

    function automatic logic [63:0] beat(input int i);
        return {32'h4000_0000 + 32'(i), 32'h3F80_0000 + 32'(i)};
    endfunction

    // Reference for the LATENCY=5 line: each beat carries its count of enabled edges seen.
    localparam int RLat = 5;
    logic [31:0] m_data[$];
    int          m_age[$];
    int          m_popped  = 0;
    int          dut_taken = 0;

    initial begin
        int exp_inf;
        logic exp_v;

        a_drive(1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        z_rst = 1'b0; z_en = 1'b1; z_valid = 1'b0; z_flush = 1'b0; z_fp = '0;
        r_rst = 1'b1; r_en = 1'b1; r_valid = 1'b0; r_flush = 1'b0; r_fp = '0;
        tick();
        tick();
        check("rst_l3_valid", 64'(a_valid_o), 64'd0);
        check("rst_l3_inflight", 64'(a_inf), 64'd0);
        check("rst_l3_data", a_fp_o, 64'd0);
        check("rst_l5_valid", 64'(r_valid_o), 64'd0);
        check("rst_l5_inflight", 64'(r_inf), 64'd0);
        r_rst = 1'b0;

        // Four back-to-back beats through three stages.
        for (int c = 0; c < 8; c++) begin
            a_drive(1'b0, 1'b1, c < 4, 1'b0, (c < 4) ? beat(c) : 64'd0);
            tick();
            exp_v   = (c >= 2 && c <= 5);
            exp_inf = (c < 4 ? c + 1 : 4) - (c < 2 ? 0 : (c - 2 > 4 ? 4 : c - 2));
            check($sformatf("burst_valid_c%0d", c), 64'(a_valid_o), 64'(exp_v));
            check($sformatf("burst_inflight_c%0d", c), 64'(a_inf), 64'(exp_inf));
            if (exp_v) check($sformatf("burst_data_c%0d", c), a_fp_o, beat(c - 2));
        end

        // Stall: one beat, four held edges carrying ignored input beats.
        a_drive(1'b0, 1'b1, 1'b1, 1'b0, beat(20));
        tick();
        check("stall_inflight_c0", 64'(a_inf), 64'd1);
        for (int c = 1; c <= 4; c++) begin
            a_drive(1'b0, 1'b0, 1'b1, 1'b0, beat(30 + c));
            tick();
            check($sformatf("stall_valid_c%0d", c), 64'(a_valid_o), 64'd0);
            check($sformatf("stall_inflight_c%0d", c), 64'(a_inf), 64'd1);
        end
        a_drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("stall_valid_c5", 64'(a_valid_o), 64'd0);
        tick();
        check("stall_valid_c6", 64'(a_valid_o), 64'd1);
        check("stall_data_c6", a_fp_o, beat(20));
        a_drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        check("stall_hold_valid", 64'(a_valid_o), 64'd1);
        check("stall_hold_data", a_fp_o, beat(20));
        check("stall_hold_inflight", 64'(a_inf), 64'd1);
        a_drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        check("stall_drain_valid", 64'(a_valid_o), 64'd0);
        check("stall_drain_inflight", 64'(a_inf), 64'd0);

        // Flush with three beats in flight and a beat offered in the flush cycle.
        for (int c = 0; c < 3; c++) begin
            a_drive(1'b0, 1'b1, 1'b1, 1'b0, beat(40 + c));
            tick();
        end
        check("flush_pre_inflight", 64'(a_inf), 64'd3);
        a_drive(1'b0, 1'b1, 1'b1, 1'b1, beat(50));
        tick();
        check("flush_inflight", 64'(a_inf), 64'd0);
        check("flush_valid", 64'(a_valid_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            a_drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            tick();
            check($sformatf("flush_after_valid_c%0d", c), 64'(a_valid_o), 64'd0);
            check($sformatf("flush_after_inflight_c%0d", c), 64'(a_inf), 64'd0);
        end

        // Reset with two beats in flight; data registers clear as well.
        for (int c = 0; c < 2; c++) begin
            a_drive(1'b0, 1'b1, 1'b1, 1'b0, beat(60 + c));
            tick();
        end
        a_drive(1'b1, 1'b1, 1'b1, 1'b0, beat(70));
        tick();
        check("midrst_valid", 64'(a_valid_o), 64'd0);
        check("midrst_inflight", 64'(a_inf), 64'd0);
        check("midrst_data", a_fp_o, 64'd0);
        for (int c = 0; c < 3; c++) begin
            a_drive(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            tick();
            check($sformatf("midrst_after_valid_c%0d", c), 64'(a_valid_o), 64'd0);
            check($sformatf("midrst_after_data_c%0d", c), a_fp_o, 64'd0);
        end

        // Pass-through: same-cycle data, flush masks valid, reset is irrelevant.
        z_fp = 32'hC049_0FDB;
        z_valid = 1'b1;
        #1;
        check("l0_data", 64'(z_fp_o), 64'hC049_0FDB);
        check("l0_valid", 64'(z_valid_o), 64'd1);
        check("l0_inflight", 64'(z_inf), 64'd0);
        z_flush = 1'b1;
        #1;
        check("l0_flush_valid", 64'(z_valid_o), 64'd0);
        z_flush = 1'b0;
        z_rst = 1'b1;
        tick();
        check("l0_rst_valid", 64'(z_valid_o), 64'd1);
        check("l0_rst_data", 64'(z_fp_o), 64'hC049_0FDB);

        // Random stress at LATENCY=5 against the age-tracking queue.
        for (int c = 0; c < 10000; c++) begin
            r_valid = ($urandom_range(0, 9) < 6);
            r_en    = ($urandom_range(0, 3) != 0);
            r_flush = ($urandom_range(0, 31) == 0);
            r_rst   = ($urandom_range(0, 499) == 0);
            r_fp    = $urandom;
            if (r_valid_o && r_en && !r_flush && !r_rst) dut_taken++;
            if (r_rst || r_flush) begin
                m_data.delete();
                m_age.delete();
            end else if (r_en) begin
                if (m_age.size() > 0 && m_age[0] == RLat) begin
                    void'(m_data.pop_front());
                    void'(m_age.pop_front());
                    m_popped++;
                end
                foreach (m_age[i]) m_age[i]++;
                if (r_valid) begin
                    m_data.push_back(r_fp);
                    m_age.push_back(1);
                end
            end
            tick();
            exp_v = (m_age.size() > 0 && m_age[0] == RLat);
            check("rnd_valid", 64'(r_valid_o), 64'(exp_v));
            check("rnd_inflight", 64'(r_inf), 64'(m_data.size()));
            check("rnd_cnt_bound", 64'(r_inf <= 3'(RLat)), 64'd1);
            if (exp_v) check("rnd_data", 64'(r_fp_o), 64'(m_data[0]));
        end
        check("rnd_emerged_count", 64'(dut_taken), 64'(m_popped));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
